data_mem: RTL and testbench

Word-organised data memory for the RVX AES CPU, serving the CPU load/store port.
- Byte-lane write strobes, combinational read, asynchronous active-low clear.
- Sits beside the instruction memory. Directly connected to the CPU dm* bus; no bus fabric.

---
 rtl/data_mem.sv | 40 ++++
 tb/tb_data_mem.sv | 107 ++++++++++
 2 files changed

// File: rtl/data_mem.sv
// data_mem: word-organised CPU data memory with byte-lane strobes, combinational read, async active-low clear
module data_mem #(
    parameter int BUS_W  = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] dmAddrIn,
    input  logic             dmWeIn,
    input  logic             dmReIn,
    input  logic [3:0]       dmDataWIn,
    input  logic [BUS_W-1:0] dmWDataIn,
    output logic [BUS_W-1:0] dmRDataOut
);
    logic [BUS_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] w_idx;
    logic              w_in_range;
    logic              w_unused;

    assign w_idx      = dmAddrIn[ADDR_W+1:2];
    assign w_in_range = dmAddrIn[BUS_W-1:ADDR_W+2] == '0;
    assign w_unused   = &{1'b0, dmAddrIn[1:0]};

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        // each word clears on reset and takes only its strobed lanes on an in-range write
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                r_mem[w] <= '0;
            else if (dmWeIn && w_in_range && w_idx == ADDR_W'(w))
                for (int b = 0; b < 4; b++)
                    if (dmDataWIn[b]) r_mem[w][8*b +: 8] <= dmWDataIn[8*b +: 8];
        end
    end

    // zero-latency read, forced to zero in reset, when disabled, or out of range
    always_comb begin
        dmRDataOut = (rst && dmReIn && w_in_range) ? r_mem[w_idx] : '0;
    end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed and random checks of data_mem against a word-array reference model
module tb_data_mem;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmAddrIn;
    logic        dmWeIn;
    logic        dmReIn;
    logic [3:0]  dmDataWIn;
    logic [31:0] dmWDataIn;
    logic [31:0] dmRDataOut;

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [31:0] m [1024];

    data_mem dut (
        .clk(clk), .rst(rst), .dmAddrIn(dmAddrIn), .dmWeIn(dmWeIn), .dmReIn(dmReIn),
        .dmDataWIn(dmDataWIn), .dmWDataIn(dmWDataIn), .dmRDataOut(dmRDataOut)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mdl_rd(input logic [31:0] a, input logic re);
        return (re && a < 32'h1000) ? m[a / 4] : 32'h0;
    endfunction

    task automatic mdl_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        if (a < 32'h1000)
            for (int i = 0; i < 4; i++)
                if (s[i]) m[a / 4][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic rd(input logic [31:0] a, input logic re, input logic [31:0] exp, input string tag);
        @(negedge clk);
        dmWeIn = 1'b0; dmReIn = re; dmAddrIn = a;
        #1 chk(tag, dmRDataOut, exp);
        chk({tag, "_mdl"}, dmRDataOut, mdl_rd(a, re));
    endtask

    task automatic step(input logic we, input logic re, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        dmWeIn = we; dmReIn = re; dmDataWIn = s; dmAddrIn = a; dmWDataIn = d;
        #1 chk({tag, "_pre"}, dmRDataOut, mdl_rd(a, re));
        @(posedge clk);
        if (we) mdl_wr(a, s, d);
        #1 chk({tag, "_post"}, dmRDataOut, mdl_rd(a, re));
    endtask

    initial begin
        foreach (m[i]) m[i] = 32'h0;
        rst = 1'b0; dmWeIn = 1'b0; dmReIn = 1'b1; dmDataWIn = 4'h0; dmAddrIn = 32'h0; dmWDataIn = 32'h0;
        #1 chk("in_reset", dmRDataOut, 32'h0);
        #5 rst = 1'b1;
        rd(32'h0, 1'b1, 32'h0, "rst_0x00");
        rd(32'h4, 1'b1, 32'h0, "rst_0x04");
        rd(32'h3FFC, 1'b1, 32'h0, "rst_0x3ffc");

        step(1'b1, 1'b0, 4'b1111, 32'h10, 32'hDEADBEEF, "sw");
        rd(32'h10, 1'b1, 32'hDEADBEEF, "rd_0x10");
        rd(32'h11, 1'b1, 32'hDEADBEEF, "rd_0x11");
        rd(32'h13, 1'b1, 32'hDEADBEEF, "rd_0x13");

        step(1'b1, 1'b0, 4'b0010, 32'h10, 32'h0000AA00, "sb1");
        rd(32'h10, 1'b1, 32'hDEADAAEF, "lane1");
        step(1'b1, 1'b0, 4'b1100, 32'h10, 32'h12340000, "sh_hi");
        rd(32'h10, 1'b1, 32'h1234AAEF, "lane23");

        rd(32'h10, 1'b0, 32'h0, "re_off");
        step(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, "zero_strb");
        rd(32'h10, 1'b1, 32'h1234AAEF, "zero_strb_word");

        step(1'b1, 1'b0, 4'b1111, 32'h1000, 32'h55555555, "oor_wr");
        rd(32'h1000, 1'b1, 32'h0, "oor_rd");
        rd(32'h0, 1'b1, 32'h0, "no_alias");

        step(1'b1, 1'b1, 4'b1111, 32'h20, 32'h11111111, "rw_same");
        @(negedge clk);
        dmWeIn = 1'b0; dmReIn = 1'b1; dmAddrIn = 32'h20;
        #1 chk("rw_new", dmRDataOut, 32'h11111111);
        #1 rst = 1'b0;
        foreach (m[i]) m[i] = 32'h0;
        #1 chk("async_rst", dmRDataOut, 32'h0);
        #1 rst = 1'b1;
        rd(32'h20, 1'b1, 32'h0, "after_rst");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 32'h11FF));
            step(1'($urandom), 1'($urandom), 4'($urandom), a, $urandom, "rand");
        end
        for (int n = 0; n < 64; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 32'h0FFF));
            rd(a, 1'b1, mdl_rd(a, 1'b1), "sweep");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
